fir_chan_sched: RTL and testbench

- Channel scheduler in front of a single shared FIR MAC engine.
- Accepts one CHANNELS-wide input frame per handshake and serializes it into per-channel sample beats for the engine, skipping masked channels.
- Tracks the decimation phase and flags the beats whose frame must produce a decimated output.
- Holds off new frames until the engine signals completion of every compute beat.

---
 rtl/fir_chan_sched.sv | 144 ++++++++++++++
 tb/tb_fir_chan_sched.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_chan_sched.sv
// fir_chan_sched: serializes masked multi-channel frames into per-channel beats for one shared FIR MAC engine.
// Optional build macro FIR_SCHED_STATS_EN adds the stat_frames / stat_stalls counters.
module fir_chan_sched #(
  parameter int CHANNELS   = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DECIM      = 8,
  localparam int CH_W      = $clog2(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           s_tvalid,
  output logic                           s_tready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_tdata,
  input  logic [CHANNELS-1:0]            chan_mask,
  output logic                           eng_valid,
  input  logic                           eng_ready,
  output logic [CH_W-1:0]                eng_chan,
  output logic signed [DATA_WIDTH-1:0]   eng_sample,
  output logic                           eng_compute,
  input  logic                           eng_done,
  output logic                           busy,
  output logic                           err
`ifdef FIR_SCHED_STATS_EN
  ,
  output logic [31:0]                    stat_frames,
  output logic [31:0]                    stat_stalls
`endif
);
  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int CNT_W = CH_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] frame_q [CHANNELS];
  logic [CHANNELS-1:0] mask_q;
  logic [CH_W-1:0]     ptr, ptr_nxt, first_idx, next_idx;
  logic                first_found, next_found;
  logic                compute_flag;
  logic [PH_W-1:0]     phase;
  logic [CNT_W-1:0]    outstanding, outstanding_nxt;
  logic                accept, beat_take, inc, err_hit;

  // Lowest set bit of the live mask (for acceptance) and next set bit above ptr in the snapshot.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (chan_mask[i]) begin
        first_found = 1'b1;
        first_idx   = CH_W'(i);
      end
      if (mask_q[i] && (CH_W'(i) > ptr)) begin
        next_found = 1'b1;
        next_idx   = CH_W'(i);
      end
    end
  end

  assign accept    = s_tvalid && s_tready;
  assign eng_valid = (state == ISSUE);
  assign beat_take = eng_valid && eng_ready;
  assign inc       = beat_take && compute_flag;
  assign err_hit   = eng_done && !inc && (outstanding == '0);

  // A simultaneous beat acceptance and completion cancel out.
  always_comb begin
    outstanding_nxt = outstanding;
    if (inc && !eng_done)
      outstanding_nxt = outstanding + 1'b1;
    else if (eng_done && !inc && (outstanding != '0))
      outstanding_nxt = outstanding - 1'b1;
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    unique case (state)
      IDLE:
        if (accept && first_found) begin
          state_nxt = ISSUE;
          ptr_nxt   = first_idx;
        end
      ISSUE:
        if (beat_take) begin
          if (next_found) ptr_nxt = next_idx;
          else            state_nxt = compute_flag ? DRAIN : IDLE;
        end
      DRAIN:
        if (outstanding_nxt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      s_tready     <= 1'b0;
      ptr          <= '0;
      mask_q       <= '0;
      compute_flag <= 1'b0;
      phase        <= '0;
      outstanding  <= '0;
      err          <= 1'b0;
    end else begin
      state       <= state_nxt;
      s_tready    <= (state_nxt == IDLE);
      ptr         <= ptr_nxt;
      outstanding <= outstanding_nxt;
      if (err_hit) err <= 1'b1;
      if (accept) begin
        mask_q       <= chan_mask;
        compute_flag <= (phase == PH_W'(DECIM - 1));
        phase        <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + 1'b1;
      end
    end
  end

  // Frame samples are pure data and carry no reset; outputs are gated by eng_valid instead.
  always_ff @(posedge clk) begin
    if (accept)
      for (int k = 0; k < CHANNELS; k++)
        frame_q[k] <= s_tdata[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign busy        = (state != IDLE);
  assign eng_chan    = eng_valid ? ptr : '0;
  assign eng_sample  = eng_valid ? frame_q[ptr] : '0;
  assign eng_compute = eng_valid && compute_flag;

`ifdef FIR_SCHED_STATS_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stat_frames <= '0;
      stat_stalls <= '0;
    end else begin
      if (accept)                  stat_frames <= stat_frames + 1'b1;
      if (eng_valid && !eng_ready) stat_stalls <= stat_stalls + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fir_chan_sched.sv
// tb_fir_chan_sched: randomized self-checking bench for fir_chan_sched against a frame-level reference model.
// Compile with FIR_SCHED_STATS_EN defined to also check the statistics counters.
module tb_fir_chan_sched;
  localparam int CH = 16, DW = 16, DEC = 8, CHW = 4;

  logic                 clk = 1'b0, nrst = 1'b0;
  logic                 s_tvalid = 1'b0, s_tready;
  logic [CH*DW-1:0]     s_tdata = '0;
  logic [CH-1:0]        chan_mask = '0;
  logic                 eng_valid, eng_ready = 1'b0;
  logic [CHW-1:0]       eng_chan;
  logic signed [DW-1:0] eng_sample;
  logic                 eng_compute, eng_done = 1'b0, busy, err;
`ifdef FIR_SCHED_STATS_EN
  logic [31:0]          stat_frames, stat_stalls;
`endif

  fir_chan_sched #(.CHANNELS(CH), .DATA_WIDTH(DW), .DECIM(DEC)) dut (
    .clk(clk), .nrst(nrst), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .chan_mask(chan_mask), .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_chan(eng_chan),
    .eng_sample(eng_sample), .eng_compute(eng_compute), .eng_done(eng_done), .busy(busy), .err(err)
`ifdef FIR_SCHED_STATS_EN
    , .stat_frames(stat_frames), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  // Reference model: frames since reset decide the compute flag; mask order decides the beats.
  int                   model_frames = 0;
  int                   exp_chan[$];
  logic signed [DW-1:0] exp_samp[$];
  bit                   exp_comp;

  int                   obs_chan[$];
  logic signed [DW-1:0] obs_samp[$];
  bit                   obs_comp[$];
  int stall_viol, stall_cnt, first_lat, span, ready_lag, timeout;

  function automatic void model_frame(input logic [CH*DW-1:0] data, input logic [CH-1:0] mask);
    exp_chan.delete();
    exp_samp.delete();
    for (int k = 0; k < CH; k++)
      if (mask[k]) begin
        exp_chan.push_back(k);
        exp_samp.push_back(data[k*DW +: DW]);
      end
    exp_comp = ((model_frames % DEC) == DEC - 1);
    model_frames++;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0; s_tvalid = 1'b0; eng_ready = 1'b0; eng_done = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    model_frames = 0;
    @(negedge clk);
  endtask

  // Offers one frame, plays the engine (ready/stalls/done pulses) and records the accepted beats.
  task automatic send_frame(input logic [CH*DW-1:0] data, input logic [CH-1:0] mask,
                            input int stall_pct, input int hold_first, input bit auto_done);
    int n, pend, wait_c, acc_cyc, first_cyc, last_cyc, hold, p_chan;
    bit prev_stall, p_comp, fin;
    logic signed [DW-1:0] p_samp;
    obs_chan.delete(); obs_samp.delete(); obs_comp.delete();
    stall_viol = 0; stall_cnt = 0; first_lat = -1; span = 0; ready_lag = -1; timeout = 0;
    pend = 0; prev_stall = 0; hold = hold_first; first_cyc = -1; last_cyc = -1; fin = 0;
    p_chan = 0; p_comp = 0; p_samp = '0;
    n = $countones(mask);
    @(negedge clk);
    s_tdata = data; chan_mask = mask; s_tvalid = 1'b1;
    wait_c = 0;
    while (!s_tready && wait_c < 200) begin
      @(negedge clk);
      wait_c++;
    end
    if (!s_tready) begin
      timeout = 1;
      s_tvalid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    @(negedge clk);
    s_tvalid = 1'b0;
    chan_mask = CH'($urandom);
    s_tdata = {8{$urandom}};
    for (int t = 0; t < 1000; t++) begin
      eng_done = 1'b0;
      if (obs_chan.size() == n && (auto_done ? (pend == 0 && s_tready) : !eng_valid)) begin
        fin = 1;
        if (last_cyc >= 0) ready_lag = cyc - last_cyc;
        break;
      end
      if (auto_done && pend > 0 && $urandom_range(1) == 1) begin
        eng_done = 1'b1;
        pend--;
      end
      if (prev_stall && (!eng_valid || int'(eng_chan) != p_chan || eng_sample !== p_samp ||
                         eng_compute !== p_comp))
        stall_viol++;
      if (eng_valid) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          first_lat = cyc - acc_cyc;
        end
        if (hold > 0) begin
          eng_ready = 1'b0;
          hold--;
        end else begin
          eng_ready = (int'($urandom_range(99)) >= stall_pct);
        end
        if (eng_ready) begin
          obs_chan.push_back(int'(eng_chan));
          obs_samp.push_back(eng_sample);
          obs_comp.push_back(eng_compute);
          if (eng_compute) pend++;
          last_cyc = cyc;
        end else begin
          stall_cnt++;
        end
        prev_stall = !eng_ready;
        p_chan = int'(eng_chan); p_samp = eng_sample; p_comp = eng_compute;
      end else begin
        eng_ready = ($urandom_range(1) == 1);
        prev_stall = 0;
      end
      @(negedge clk);
    end
    eng_done = 1'b0;
    eng_ready = 1'b0;
    if (!fin) timeout = 1;
    if (first_cyc >= 0) span = last_cyc - first_cyc + 1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b expected 0", s_tready); end
    n_tests++; if (eng_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", eng_valid); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (eng_chan !== '0 || eng_sample !== '0 || eng_compute !== 1'b0) begin
      n_fail++; $display("FAIL reset_eng: got ch%0d s%0d c%b expected 0/0/0", eng_chan, eng_sample, eng_compute);
    end
    nrst = 1'b1;
    model_frames = 0;
    @(posedge clk); #1;
    n_tests++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL reset_release_tready: got %b expected 1", s_tready); end
  endtask

  task automatic test_impulse();
    logic [CH*DW-1:0] d;
    d = '0;
    d[DW-1:0] = 16'h7FFF;
    model_frame(d, 16'hFFFF);
    send_frame(d, 16'hFFFF, 0, 0, 1'b1);
    n_tests++; if (timeout != 0) begin n_fail++; $display("FAIL impulse_timeout: got %0d expected 0", timeout); end
    n_tests++; if (obs_chan.size() != 16) begin n_fail++; $display("FAIL impulse_count: got %0d expected 16", obs_chan.size()); end
    for (int k = 0; k < obs_chan.size() && k < exp_chan.size(); k++) begin
      n_tests++;
      if (obs_chan[k] != exp_chan[k] || obs_samp[k] !== exp_samp[k] || obs_comp[k] !== exp_comp) begin
        n_fail++;
        $display("FAIL impulse_beat%0d: got ch%0d s%0d c%0d expected ch%0d s%0d c%0d", k,
                 obs_chan[k], obs_samp[k], obs_comp[k], exp_chan[k], exp_samp[k], exp_comp);
      end
    end
    n_tests++; if (first_lat != 1) begin n_fail++; $display("FAIL impulse_latency: got %0d expected 1", first_lat); end
    n_tests++; if (span != 16) begin n_fail++; $display("FAIL impulse_span: got %0d expected 16", span); end
    n_tests++; if (ready_lag != 1) begin n_fail++; $display("FAIL impulse_tready_after: got %0d expected 1", ready_lag); end
  endtask

  task automatic test_eight_frames();
    logic [CH*DW-1:0] d;
    do_reset();
    for (int f = 0; f < 8; f++) begin
      d = {8{$urandom}};
      model_frame(d, 16'hFFFF);
      send_frame(d, 16'hFFFF, 20, 0, (f < 7));
      n_tests++;
      if (timeout != 0 || obs_chan.size() != 16) begin
        n_fail++; $display("FAIL eight_f%0d_count: got %0d (timeout %0d) expected 16", f, obs_chan.size(), timeout);
      end
      for (int k = 0; k < obs_chan.size() && k < exp_chan.size(); k++) begin
        n_tests++;
        if (obs_chan[k] != exp_chan[k] || obs_samp[k] !== exp_samp[k] || obs_comp[k] !== exp_comp) begin
          n_fail++;
          $display("FAIL eight_f%0d_beat%0d: got ch%0d s%0d c%0d expected ch%0d s%0d c%0d", f, k,
                   obs_chan[k], obs_samp[k], obs_comp[k], exp_chan[k], exp_samp[k], exp_comp);
        end
      end
    end
    n_tests++; if (s_tready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL drain_entry: got tready %b busy %b expected 0/1", s_tready, busy);
    end
    for (int d_i = 1; d_i <= 16; d_i++) begin
      eng_done = 1'b1;
      @(negedge clk);
      eng_done = 1'b0;
      n_tests++;
      if (d_i < 16 && (s_tready !== 1'b0 || busy !== 1'b1)) begin
        n_fail++; $display("FAIL drain_done%0d: got tready %b busy %b expected 0/1", d_i, s_tready, busy);
      end else if (d_i == 16 && (s_tready !== 1'b1 || busy !== 1'b0)) begin
        n_fail++; $display("FAIL drain_exit: got tready %b busy %b expected 1/0", s_tready, busy);
      end
    end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL drain_err: got %b expected 0", err); end
  endtask

  task automatic test_sparse_stall();
    logic [CH*DW-1:0] d;
`ifdef FIR_SCHED_STATS_EN
    logic [31:0] st0, fr0;
`endif
    d = '0;
    d[0*DW +: DW] = 16'sd100;
    d[4*DW +: DW] = -16'sd5;
    model_frame(d, 16'h0011);
`ifdef FIR_SCHED_STATS_EN
    @(negedge clk);
    st0 = stat_stalls;
    fr0 = stat_frames;
`endif
    send_frame(d, 16'h0011, 0, 3, 1'b1);
    n_tests++; if (timeout != 0 || obs_chan.size() != 2) begin
      n_fail++; $display("FAIL sparse_count: got %0d (timeout %0d) expected 2", obs_chan.size(), timeout);
    end
    for (int k = 0; k < obs_chan.size() && k < exp_chan.size(); k++) begin
      n_tests++;
      if (obs_chan[k] != exp_chan[k] || obs_samp[k] !== exp_samp[k] || obs_comp[k] !== exp_comp) begin
        n_fail++;
        $display("FAIL sparse_beat%0d: got ch%0d s%0d c%0d expected ch%0d s%0d c%0d", k,
                 obs_chan[k], obs_samp[k], obs_comp[k], exp_chan[k], exp_samp[k], exp_comp);
      end
    end
    n_tests++; if (stall_viol != 0) begin n_fail++; $display("FAIL sparse_stall_stable: got %0d changes expected 0", stall_viol); end
    n_tests++; if (stall_cnt != 3) begin n_fail++; $display("FAIL sparse_stall_cycles: got %0d expected 3", stall_cnt); end
`ifdef FIR_SCHED_STATS_EN
    n_tests++; if (stat_stalls - st0 != 32'd3) begin
      n_fail++; $display("FAIL stat_stalls: got %0d expected 3", stat_stalls - st0);
    end
    n_tests++; if (stat_frames - fr0 != 32'd1) begin
      n_fail++; $display("FAIL stat_frames: got %0d expected 1", stat_frames - fr0);
    end
`endif
  endtask

  task automatic test_zero_mask();
    logic [CH*DW-1:0] d;
    do_reset();
    for (int f = 0; f < 7; f++) begin
      d = {8{$urandom}};
      model_frame(d, '0);
      send_frame(d, '0, 0, 0, 1'b1);
      n_tests++;
      if (timeout != 0 || obs_chan.size() != 0 || s_tready !== 1'b1) begin
        n_fail++; $display("FAIL zero_f%0d: got %0d beats tready %b expected 0 beats tready 1", f, obs_chan.size(), s_tready);
      end
    end
    d = {8{$urandom}};
    model_frame(d, 16'h0001);
    send_frame(d, 16'h0001, 0, 0, 1'b1);
    n_tests++;
    if (timeout != 0 || obs_chan.size() != 1) begin
      n_fail++; $display("FAIL zero_next_count: got %0d expected 1", obs_chan.size());
    end else if (obs_chan[0] != 0 || obs_samp[0] !== exp_samp[0] || obs_comp[0] !== 1'b1 || exp_comp !== 1'b1) begin
      n_fail++; $display("FAIL zero_next_beat: got ch%0d s%0d c%0d expected ch0 s%0d c1",
                         obs_chan[0], obs_samp[0], obs_comp[0], exp_samp[0]);
    end
  endtask

  task automatic test_random();
    logic [CH*DW-1:0] d;
    logic [CH-1:0] m;
    for (int f = 0; f < 24; f++) begin
      d = {8{$urandom}};
      case ($urandom_range(3))
        0:       m = '0;
        1:       m = '1;
        default: m = CH'($urandom);
      endcase
      model_frame(d, m);
      send_frame(d, m, 30, 0, 1'b1);
      n_tests++;
      if (timeout != 0 || obs_chan.size() != exp_chan.size()) begin
        n_fail++; $display("FAIL rand_f%0d_count: got %0d (timeout %0d) expected %0d", f, obs_chan.size(), timeout, exp_chan.size());
      end
      n_tests++; if (stall_viol != 0) begin n_fail++; $display("FAIL rand_f%0d_stable: got %0d expected 0", f, stall_viol); end
      for (int k = 0; k < obs_chan.size() && k < exp_chan.size(); k++) begin
        n_tests++;
        if (obs_chan[k] != exp_chan[k] || obs_samp[k] !== exp_samp[k] || obs_comp[k] !== exp_comp) begin
          n_fail++;
          $display("FAIL rand_f%0d_beat%0d: got ch%0d s%0d c%0d expected ch%0d s%0d c%0d", f, k,
                   obs_chan[k], obs_samp[k], obs_comp[k], exp_chan[k], exp_samp[k], exp_comp);
        end
      end
    end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rand_err: got %b expected 0", err); end
  endtask

  task automatic test_error();
    logic [CH*DW-1:0] d;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL error_idle: got busy %b expected 0", busy); end
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL error_set: got %b expected 1", err); end
    for (int f = 0; f < 2; f++) begin
      d = {8{$urandom}};
      model_frame(d, 16'h00F0);
      send_frame(d, 16'h00F0, 10, 0, 1'b1);
      n_tests++; if (err !== 1'b1 || timeout != 0) begin
        n_fail++; $display("FAIL error_sticky%0d: got err %b timeout %0d expected 1/0", f, err, timeout);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [CH*DW-1:0] d;
    int w;
    if ((model_frames % DEC) == DEC - 1) begin
      model_frame('0, '0);
      send_frame('0, '0, 0, 0, 1'b1);
    end
    d = {8{$urandom}};
    model_frame(d, 16'hFFFF);
    @(negedge clk);
    s_tdata = d; chan_mask = 16'hFFFF; s_tvalid = 1'b1; eng_ready = 1'b0;
    w = 0;
    while (!s_tready && w < 200) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    n_tests++; if (eng_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_issue: got valid %b expected 1", eng_valid); end
    #2 nrst = 1'b0;
    #1;
    n_tests++; if (eng_valid !== 1'b0 || busy !== 1'b0 || s_tready !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL midreset_async: got valid %b busy %b tready %b err %b expected 0/0/0/0",
                         eng_valid, busy, s_tready, err);
    end
    @(negedge clk);
    nrst = 1'b1;
    model_frames = 0;
    for (int f = 0; f < 7; f++) begin
      model_frame('0, '0);
      send_frame('0, '0, 0, 0, 1'b1);
      n_tests++; if (obs_chan.size() != 0 || timeout != 0) begin
        n_fail++; $display("FAIL midreset_zero%0d: got %0d beats expected 0", f, obs_chan.size());
      end
    end
    d = {8{$urandom}};
    model_frame(d, 16'h0001);
    send_frame(d, 16'h0001, 0, 0, 1'b1);
    n_tests++;
    if (obs_chan.size() != 1 || timeout != 0) begin
      n_fail++; $display("FAIL midreset_phase_count: got %0d expected 1", obs_chan.size());
    end else if (obs_comp[0] !== exp_comp || exp_comp !== 1'b1) begin
      n_fail++; $display("FAIL midreset_phase: got compute %0d expected 1", obs_comp[0]);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_impulse();
    test_eight_frames();
    test_sparse_stall();
    test_zero_mask();
    test_random();
    test_error();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
